// File: rtl/countdown_timer_dp_if.sv
// Control/setpoint inputs and time/status outputs of the countdown timer.
// The timer itself connects through the slave modport.
interface countdown_timer_dp_if;
    logic       i_load;
    logic       i_start;
    logic       i_clear;
    logic [4:0] i_set_hour;
    logic [5:0] i_set_min;
    logic [5:0] i_set_sec;
    logic [6:0] i_set_msec;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       o_running;
    logic       o_done;
    logic       o_expired;

    modport slave (
        input  i_load, i_start, i_clear, i_set_hour, i_set_min, i_set_sec, i_set_msec,
        output msec, sec, min, hour, o_running, o_done, o_expired
    );
    modport master (
        output i_load, i_start, i_clear, i_set_hour, i_set_min, i_set_sec, i_set_msec,
        input  msec, sec, min, hour, o_running, o_done, o_expired
    );
endinterface

// File: rtl/countdown_timer_dp.sv
// Countdown timer datapath: loads an h:m:s.cs setpoint and decrements it once per
// 10 ms tick down to zero, with its own IDLE/RUN/PAUSE/DONE control and prescaler.
module countdown_timer_dp #(
    parameter int FCOUNT   = 1_000_000,
    parameter int MAX_HOUR = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    countdown_timer_dp_if.slave  bus
);
    localparam int PW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
    localparam logic [PW-1:0] PLAST = PW'(FCOUNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [6:0]    msec_q, msec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic          cnt_zero, cnt_one;

    assign cnt_zero = (hour_q == '0) && (min_q == '0) && (sec_q == '0) && (msec_q == '0);
    assign cnt_one  = (hour_q == '0) && (min_q == '0) && (sec_q == '0) && (msec_q == 7'd1);

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        msec_d  = msec_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        // Prescaler runs only in RUN, holds in PAUSE so a resume keeps the partial count.
        if (state_q == RUN) begin
            if (presc_q == PLAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (state_q != PAUSE) begin
            presc_d = '0;
        end

        if (bus.i_clear) begin
            {hour_d, min_d, sec_d, msec_d} = '0;
            presc_d = '0;
            tick_d  = 1'b0;
            state_d = IDLE;
        end else if (bus.i_load && state_q != RUN) begin
            hour_d  = (bus.i_set_hour > 5'(MAX_HOUR)) ? 5'(MAX_HOUR) : bus.i_set_hour;
            min_d   = (bus.i_set_min  > 6'd59) ? 6'd59 : bus.i_set_min;
            sec_d   = (bus.i_set_sec  > 6'd59) ? 6'd59 : bus.i_set_sec;
            msec_d  = (bus.i_set_msec > 7'd99) ? 7'd99 : bus.i_set_msec;
            presc_d = '0;
            tick_d  = 1'b0;
            state_d = IDLE;
        end else if (bus.i_start) begin
            // A tick landing with a pause pulse is dropped: no decrement on this path.
            case (state_q)
                IDLE:    if (!cnt_zero) state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end else if (state_q == RUN && tick_q) begin
            if (msec_q != '0) begin
                msec_d = msec_q - 1'b1;
            end else begin
                msec_d = 7'd99;
                if (sec_q != '0) begin
                    sec_d = sec_q - 1'b1;
                end else begin
                    sec_d = 6'd59;
                    if (min_q != '0) begin
                        min_d = min_q - 1'b1;
                    end else begin
                        min_d  = 6'd59;
                        hour_d = hour_q - 1'b1;
                    end
                end
            end
            if (cnt_one) begin
                state_d = DONE;
                done_d  = 1'b1;
                presc_d = '0;
                tick_d  = 1'b0;
            end
        end

        running_d = (state_d == RUN);
        expired_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            hour_q    <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            msec_q    <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            msec_q    <= msec_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign bus.hour      = hour_q;
    assign bus.min       = min_q;
    assign bus.sec       = sec_q;
    assign bus.msec      = msec_q;
    assign bus.o_running = running_q;
    assign bus.o_done    = done_q;
    assign bus.o_expired = expired_q;
endmodule

// File: tb/tb_countdown_timer_dp.sv
// Scoreboard bench for countdown_timer_dp: expected snapshots are queued with the
// cycle they are due and compared on the falling edge of that cycle.
module tb_countdown_timer_dp;
    localparam int FC = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    countdown_timer_dp_if bus();

    countdown_timer_dp #(.FCOUNT(FC), .MAX_HOUR(23)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       tag;
        int          cyc;
        logic [26:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [26:0] pk(input int h, input int m, input int s, input int c,
                                       input bit r, input bit d, input bit e);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic [6:0] cc;
        hh = 5'(h);
        mm = 6'(m);
        ss = 6'(s);
        cc = 7'(c);
        return {hh, mm, ss, cc, r, d, e};
    endfunction

    function automatic logic [26:0] obs();
        return {bus.hour, bus.min, bus.sec, bus.msec, bus.o_running, bus.o_done, bus.o_expired};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic exp_at(input string tag, input int c, input logic [26:0] v);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.val = v;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc == cyc) chk(e.tag, 32'(obs()), 32'(e.val));
            else              chk({e.tag, "_late"}, cyc, e.cyc);
        end
    end

    task automatic setp(input int h, input int m, input int s, input int c);
        bus.i_set_hour = 5'(h);
        bus.i_set_min  = 6'(m);
        bus.i_set_sec  = 6'(s);
        bus.i_set_msec = 7'(c);
    endtask

    // One-cycle pulse captured at edge 'at' (or the next edge when at==0); e = capturing edge.
    task automatic pulse(input bit ld, input bit st, input bit cl, input int at, output int e);
        @(negedge clk);
        while (at != 0 && cyc < at - 1) @(negedge clk);
        bus.i_load  = ld;
        bus.i_start = st;
        bus.i_clear = cl;
        e = cyc + 1;
        @(posedge clk);
        #1;
        bus.i_load  = 1'b0;
        bus.i_start = 1'b0;
        bus.i_clear = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, s, p, r;
        bus.i_load = 1'b0;
        bus.i_start = 1'b0;
        bus.i_clear = 1'b0;
        setp(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs()), 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic countdown, ticks every FC cycles, first one FC+1 after start
        setp(0, 0, 1, 2);
        pulse(1, 0, 0, 0, e);
        exp_at("t1_load", e, pk(0, 0, 1, 2, 0, 0, 0));
        pulse(0, 1, 0, 0, s);
        exp_at("t1_run",   s,      pk(0, 0, 1, 2, 1, 0, 0));
        exp_at("t1_pre",   s + 4,  pk(0, 0, 1, 2, 1, 0, 0));
        exp_at("t1_dec1",  s + 5,  pk(0, 0, 1, 1, 1, 0, 0));
        exp_at("t1_hold",  s + 8,  pk(0, 0, 1, 1, 1, 0, 0));
        exp_at("t1_dec2",  s + 9,  pk(0, 0, 1, 0, 1, 0, 0));
        exp_at("t1_dec3",  s + 13, pk(0, 0, 0, 99, 1, 0, 0));
        exp_at("t1_dec4",  s + 17, pk(0, 0, 0, 98, 1, 0, 0));
        drain();
        pulse(0, 0, 1, 0, e);
        exp_at("t1_clear", e, pk(0, 0, 0, 0, 0, 0, 0));
        drain();

        // Full borrow ripple
        setp(1, 0, 0, 0);
        pulse(1, 0, 0, 0, e);
        pulse(0, 1, 0, 0, s);
        exp_at("t2_pre",    s + 4, pk(1, 0, 0, 0, 1, 0, 0));
        exp_at("t2_ripple", s + 5, pk(0, 59, 59, 99, 1, 0, 0));
        drain();
        pulse(0, 0, 1, 0, e);
        drain();

        // Reaching zero: done pulse, expired level, start ignored in DONE
        setp(0, 0, 0, 2);
        pulse(1, 0, 0, 0, e);
        pulse(0, 1, 0, 0, s);
        exp_at("t3_dec1",  s + 5,  pk(0, 0, 0, 1, 1, 0, 0));
        exp_at("t3_done",  s + 9,  pk(0, 0, 0, 0, 0, 1, 1));
        exp_at("t3_exp",   s + 10, pk(0, 0, 0, 0, 0, 0, 1));
        drain();
        pulse(0, 1, 0, 0, p);
        exp_at("t3_start_ign",  p,     pk(0, 0, 0, 0, 0, 0, 1));
        exp_at("t3_still_exp",  p + 3, pk(0, 0, 0, 0, 0, 0, 1));
        drain();
        pulse(0, 0, 1, 0, e);
        exp_at("t3_clear", e, pk(0, 0, 0, 0, 0, 0, 0));
        drain();

        // Pause holds prescaler; pause coinciding with a tick drops it
        setp(0, 0, 0, 50);
        pulse(1, 0, 0, 0, e);
        pulse(0, 1, 0, 0, s);
        pulse(0, 1, 0, s + 2, p);
        exp_at("t4_paused", p,      pk(0, 0, 0, 50, 0, 0, 0));
        exp_at("t4_frozen", p + 20, pk(0, 0, 0, 50, 0, 0, 0));
        pulse(0, 1, 0, p + 22, r);
        exp_at("t4_resume",  r + 2, pk(0, 0, 0, 50, 1, 0, 0));
        exp_at("t4_dec",     r + 3, pk(0, 0, 0, 49, 1, 0, 0));
        pulse(0, 1, 0, r + 7, p);
        exp_at("t4_tickdrop", r + 7,  pk(0, 0, 0, 49, 0, 0, 0));
        exp_at("t4_tickgone", r + 12, pk(0, 0, 0, 49, 0, 0, 0));
        drain();
        pulse(0, 0, 1, 0, e);
        drain();

        // Clamping, start with zero count, load ignored in RUN, clear beats load
        setp(31, 63, 60, 127);
        pulse(1, 0, 0, 0, e);
        exp_at("t5_clamp", e, pk(23, 59, 59, 99, 0, 0, 0));
        drain();
        pulse(0, 0, 1, 0, e);
        pulse(0, 1, 0, 0, s);
        exp_at("t5_start_zero", s, pk(0, 0, 0, 0, 0, 0, 0));
        drain();
        setp(0, 0, 0, 5);
        pulse(1, 0, 0, 0, e);
        pulse(0, 1, 0, 0, s);
        setp(0, 0, 0, 7);
        pulse(1, 0, 0, s + 2, p);
        exp_at("t5_load_in_run", p,     pk(0, 0, 0, 5, 1, 0, 0));
        exp_at("t5_run_dec",     s + 5, pk(0, 0, 0, 4, 1, 0, 0));
        drain();
        setp(0, 0, 0, 9);
        pulse(1, 0, 1, 0, e);
        exp_at("t5_clear_load", e, pk(0, 0, 0, 0, 0, 0, 0));
        drain();

        // Asynchronous reset between edges mid-RUN
        setp(0, 0, 0, 5);
        pulse(1, 0, 0, 0, e);
        pulse(0, 1, 0, 0, s);
        while (cyc < s + 2) @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_reset", 32'(obs()), 0);
        @(negedge clk);
        reset = 1'b1;
        exp_at("t6_rel1", cyc + 1, pk(0, 0, 0, 0, 0, 0, 0));
        exp_at("t6_rel3", cyc + 3, pk(0, 0, 0, 0, 0, 0, 0));
        drain();
        pulse(0, 1, 0, 0, p);
        exp_at("t6_idle_zero", p, pk(0, 0, 0, 0, 0, 0, 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer_dp.md
Name: countdown_timer_dp

Overview:
- Countdown counterpart of the stopwatch datapath: loads an hour/min/sec/centisecond setpoint and decrements it once per 10 ms tick to 00:00:00.00.
- Fires a one-cycle done pulse on reaching zero, then holds an expired level.
- Contains its own control FSM (IDLE/RUN/PAUSE/DONE), 10 ms prescaler and borrow chain.
- Sits beside the stopwatch datapath and feeds the same time-display mux.

Parameters:
FCOUNT, 1_000_000, clk cycles per 10 ms tick (100 MHz clk); benches use small values.
MAX_HOUR, 23, largest hour value accepted on load.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
i_load  input  1  1-cycle pulse; captures the i_set_* fields as the new count.
i_start  input  1  1-cycle pulse; toggles run/pause.
i_clear  input  1  1-cycle pulse; zeroes the count and returns to IDLE.
i_set_hour  input  5  setpoint hours.
i_set_min  input  6  setpoint minutes.
i_set_sec  input  6  setpoint seconds.
i_set_msec  input  7  setpoint centiseconds (0-99).
msec  output  7  remaining centiseconds.
sec  output  6  remaining seconds.
min  output  6  remaining minutes.
hour  output  5  remaining hours.
o_running  output  1  high while in RUN.
o_done  output  1  1-cycle pulse when the count reaches zero.
o_expired  output  1  high while in DONE.

Behaviour:
- Reset (reset==0, async): state=IDLE, count=0, prescaler=0, tick=0; all outputs 0. Reset mid-run aborts immediately. No outputs are asserted during reset.
- Input priority in a single cycle: i_clear > i_load > i_start.
- i_clear, any state: count=0, prescaler=0, next state IDLE.
- i_load
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Each field is clamped: msec>99→99, sec>59→59, min>59→59, hour>MAX_HOUR→MAX_HOUR.
  - The new count is visible on the outputs the cycle after the load pulse.
  - Next state: IDLE; prescaler=0.
- i_start
  - IDLE→RUN only if count≠0; ignored when count==0.
  - RUN→PAUSE.
  - PAUSE→RUN.
  - Ignored in DONE; leave DONE with i_clear or i_load.
- Prescaler
  - Counts 0..FCOUNT-1, advancing only in RUN.
  - Held (not cleared) in PAUSE, so a resume continues from the partial count.
  - Cleared in IDLE and DONE.
  - At FCOUNT-1 it wraps to 0 and registers tick=1 for exactly one cycle.
  - First decrement occurs FCOUNT+1 cycles after the start pulse's edge.
- Decrement on tick (only in RUN), borrow chain:
  - msec>0: msec-1.
  - Else msec=99 and borrow from sec; sec=0→59 and borrow from min; min=0→59 and borrow from hour; hour-1.
  - Borrow never underflows hour, because RUN is never entered with count==0.
- Zero detect: the tick that takes the count from 00:00:00.01 to 0 sets state=DONE in the same edge. o_done=1 for that one cycle (registered alongside the count); o_expired=1 from the same cycle until leaving DONE.
- A tick arriving in the same cycle as an i_start (pause) pulse is dropped: the pause wins and the count is unchanged.
- o_running = (state==RUN), registered/state-decoded, glitch-free.
- All outputs are driven from registers or state decode; there are no combinational paths from inputs to outputs.

Test Plan:
- FCOUNT=4. Load 0:00:01.02, start → after 3 ticks: 0:00:00.99 then 00.98 etc.; each tick exactly 4 cycles apart; o_running=1.
- Load 1:00:00.00, start, one tick → 0:59:59.99, borrow ripples through all fields in one cycle.
- Load 0:00:00.02, start → after 2 ticks the count is 0; o_done high exactly 1 cycle, o_expired stays 1, o_running=0; further i_start pulses ignored.
- Run, pause after 2 prescaler cycles, hold 20 cycles (count frozen), resume → next tick 2 cycles later. Pause pulse coinciding with a tick → count not decremented.
- Load hour=31,min=63,sec=60,msec=127 → 23:59:59.99 visible next cycle. i_start with count 0 in IDLE → stays IDLE. i_load during RUN ignored. Simultaneous i_clear+i_load → count 0, IDLE.
- Assert reset low asynchronously mid-RUN (between edges) → all outputs 0 immediately. Release → IDLE, no o_done pulse.
